uart_rx_engine: RTL and testbench

Parametrised UART receiver that replaces the fixed-format RX control path.
- Takes a raw asynchronous rx line and an oversample tick.
- Recovers frames with mid-bit majority voting; supports 5..DATA_W_MAX data bits, none/even/odd parity, 1 or 2 stop bits.
- Presents each word plus error flags on a valid/ready holding register, with overrun and break detection.
- Sits between the baud generator and the RX FIFO/CSR block.

---
 rtl/uart_rx_engine_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 62 ++++++
 rtl/uart_rx_engine.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_engine_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the FSM state encoding, parity mode values and the vote helper.
package uart_rx_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_DATA_BITS = 5;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversample phase counter and 3-point mid-bit vote.
// Emits one bit_valid strobe per bit at phase OVERSAMPLE/2+1.
module uart_rx_sampler
    import uart_rx_engine_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rx,
    input  logic phase_clr,
    output logic rx_sync,
    output logic start_edge,
    output logic phase_wrap,
    output logic bit_valid,
    output logic bit_value
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LO   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_HI   = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [PH_W-1:0]        phase;
    logic                   s_lo;
    logic                   s_mid;

    assign rx_sync    = sync_q[SYNC_STAGES-1];
    assign start_edge = baud_tick && !rx_sync;
    assign phase_wrap = baud_tick && (phase == PH_LAST);
    assign bit_valid  = baud_tick && !phase_clr && (phase == PH_HI);
    assign bit_value  = maj3(s_lo, s_mid, rx_sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            phase  <= '0;
            s_lo   <= 1'b1;
            s_mid  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            if (baud_tick) begin
                if (phase_clr || phase == PH_LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + PH_W'(1);
                end
                if (phase == PH_LO) begin
                    s_lo <= rx_sync;
                end
                if (phase == PH_MID) begin
                    s_mid <= rx_sync;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// Configurable UART receiver: frame FSM, shift/parity logic and
// a valid/ready holding register with overrun and break reporting.
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int DATA_W_MAX  = 9,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  rx,
    input  logic [3:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_odd,
    input  logic                  cfg_stop2,
    output logic [DATA_W_MAX-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(DATA_W_MAX + 1);
    localparam logic [3:0] MAX_BITS = 4'(DATA_W_MAX);
    localparam logic [3:0] MIN_BITS = 4'(MIN_DATA_BITS);

    rx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      nbits_q;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  stop2_q;
    logic [DATA_W_MAX-1:0] frame;
    logic                  start_ok;
    logic                  stop_second;
    logic                  perr_q;
    logic                  ferr_q;
    logic                  pbit_zero;

    logic       rx_sync;
    logic       start_edge;
    logic       phase_wrap;
    logic       bit_valid;
    logic       bit_value;
    logic       phase_clr;
    logic [3:0] nbits_in;
    logic       first_stop;
    logic       done;
    logic       ferr_n;
    logic       brk_n;
    logic       last_bit;
    logic       exp_par;

    assign phase_clr = (state == ST_IDLE) || (state == ST_BREAK);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .phase_clr (phase_clr),
        .rx_sync   (rx_sync),
        .start_edge(start_edge),
        .phase_wrap(phase_wrap),
        .bit_valid (bit_valid),
        .bit_value (bit_value)
    );

    always_comb begin
        nbits_in = cfg_data_bits;
        if (cfg_data_bits < MIN_BITS) begin
            nbits_in = MIN_BITS;
        end else if (cfg_data_bits > MAX_BITS) begin
            nbits_in = MAX_BITS;
        end
        first_stop = (state == ST_STOP) && bit_valid && !stop_second;
        done       = (state == ST_STOP) && bit_valid
                     && (stop_second || !stop2_q);
        ferr_n     = first_stop ? !bit_value : ferr_q;
        // A break is an all-zero frame including stop and any parity bit.
        brk_n      = (frame == '0) && ferr_n && (!par_en_q || pbit_zero);
        last_bit   = (bit_cnt == nbits_q - CNT_W'(1));
        exp_par    = (^frame) ^ (par_odd_q == PAR_ODD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            nbits_q     <= CNT_W'(MIN_DATA_BITS);
            par_en_q    <= 1'b0;
            par_odd_q   <= PAR_EVEN;
            stop2_q     <= 1'b0;
            frame       <= '0;
            start_ok    <= 1'b0;
            stop_second <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            pbit_zero   <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= frame;
                    parity_err <= perr_q;
                    frame_err  <= ferr_n;
                    break_det  <= brk_n;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state       <= ST_START;
                        nbits_q     <= CNT_W'(nbits_in);
                        par_en_q    <= cfg_parity_en;
                        par_odd_q   <= cfg_parity_odd;
                        stop2_q     <= cfg_stop2;
                        bit_cnt     <= '0;
                        frame       <= '0;
                        start_ok    <= 1'b0;
                        stop_second <= 1'b0;
                        perr_q      <= 1'b0;
                        ferr_q      <= 1'b0;
                        pbit_zero   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_valid) begin
                        if (bit_value) begin
                            state <= ST_IDLE;
                        end else begin
                            start_ok <= 1'b1;
                        end
                    end else if (phase_wrap && start_ok) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        frame[bit_cnt] <= bit_value;
                        bit_cnt        <= bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            state <= par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        perr_q    <= (bit_value != exp_par);
                        pbit_zero <= !bit_value;
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (first_stop) begin
                        ferr_q      <= !bit_value;
                        stop_second <= 1'b1;
                    end
                    if (done) begin
                        state <= brk_n ? ST_BREAK : ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (baud_tick && rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: directed frames in, words and
// flags compared at each accepting handshake.
module tb_uart_rx_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b1;
    logic       rx = 1'b1;
    logic [3:0] cfg_data_bits = 4'd8;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       overrun;

    typedef struct packed {
        logic [8:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   ovr_cnt = 0;

    uart_rx_engine #(
        .DATA_W_MAX (9),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .rx            (rx),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .break_det     (break_det),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic expect_word(input logic [8:0] d, input logic p,
                               input logic f, input logic b);
        exp_t e;
        e.d = d;
        e.p = p;
        e.f = f;
        e.b = b;
        sb.push_back(e);
    endtask

    task automatic bit_time(input logic b);
        rx = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] d, input int n, input logic pen,
                        input logic podd, input logic pflip,
                        input logic stopv, input logic s2);
        logic p;
        cfg_data_bits  = 4'(n);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
        bit_time(1'b0);
        p = podd;
        for (int i = 0; i < n; i++) begin
            bit_time(d[i]);
            p = p ^ d[i];
        end
        if (pen) begin
            bit_time(p ^ pflip);
        end
        bit_time(stopv);
        if (s2) begin
            bit_time(1'b1);
        end
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && overrun) begin
            ovr_cnt++;
        end
        if (!rst && rx_valid && rx_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%0h exp=none", rx_data);
            end else begin
                mon_e = sb.pop_front();
                if ({rx_data, parity_err, frame_err, break_det} !== mon_e) begin
                    failures++;
                    $display("FAIL sb_word got=%0h/%b%b%b exp=%0h/%b%b%b",
                             rx_data, parity_err, frame_err, break_det,
                             mon_e.d, mon_e.p, mon_e.f, mon_e.b);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_flags", 32'({parity_err, frame_err, break_det}), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        idle(32);

        // 8N1 0xA5 held until ready
        rx_ready = 1'b0;
        expect_word(9'h0A5, 1'b0, 1'b0, 1'b0);
        send(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        check("hold_valid", 32'(rx_valid), 1);
        check("hold_data", 32'(rx_data), 32'h0A5);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("clear_after_ready", 32'(rx_valid), 0);
        idle(16);

        // 7E1 0x41, parity bit forced to 1
        expect_word(9'h041, 1'b1, 1'b0, 1'b0);
        send(9'h041, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(32);

        // 9O1 0x1FF
        expect_word(9'h1FF, 1'b0, 1'b0, 1'b0);
        send(9'h1FF, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(32);

        // 8N1 0x3C with stop bit 0
        expect_word(9'h03C, 1'b0, 1'b1, 1'b0);
        send(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(32);

        // break: line low 12 bit-times
        cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_stop2     = 1'b0;
        expect_word(9'h000, 1'b0, 1'b1, 1'b1);
        rx = 1'b0;
        repeat (192) @(posedge clk);
        #1;
        check("brk_no_extra", 32'(rx_valid), 0);
        check("brk_pending", 32'(sb.size()), 0);
        idle(16);
        expect_word(9'h05A, 1'b0, 1'b0, 1'b0);
        send(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(32);

        // 5-tick glitch in idle
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(48);
        check("glitch_no_valid", 32'(rx_valid), 0);
        expect_word(9'h096, 1'b0, 1'b0, 1'b0);
        send(9'h096, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(32);

        // back-to-back 8N2
        expect_word(9'h055, 1'b0, 1'b0, 1'b0);
        expect_word(9'h0AA, 1'b0, 1'b0, 1'b0);
        send(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(9'h0AA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(32);
        check("b2b_drained", 32'(sb.size()), 0);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        ovr_cnt  = 0;
        expect_word(9'h011, 1'b0, 1'b0, 1'b0);
        send(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        check("ovr_keep", 32'(rx_data), 32'h011);
        check("ovr_valid", 32'(rx_valid), 1);
        check("ovr_pulses", 32'(ovr_cnt), 1);
        check("ovr_flags", 32'({parity_err, frame_err, break_det}), 0);

        // reset in the middle of a third frame
        cfg_data_bits = 4'd8;
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rst = 1'b1;
        rx  = 1'b1;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_valid", 32'(rx_valid), 0);
        check("rst_mid_data", 32'(rx_data), 0);
        check("rst_mid_flags",
              32'({parity_err, frame_err, break_det, overrun}), 0);
        rst = 1'b0;
        rx_ready = 1'b1;
        idle(32);
        expect_word(9'h033, 1'b0, 1'b0, 1'b0);
        send(9'h033, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
